// File: rtl/sram_wb_controller.sv
// Wishbone pipelined slave driving an external asynchronous 16-bit SRAM.
// Each pin-level access holds address, byte lanes and controls stable for a
// programmable number of clocks. A write then spends one extra hold cycle
// with the data still driven after we_n rises.
//
// Handshake: a request is taken on a clock edge where i_wb_cyc && i_wb_stb
// && !o_wb_stall. o_wb_stall is high whenever the FSM is outside IDLE.
// o_wb_ack is a single-cycle pulse per accepted request. It is withheld when
// i_wb_cyc dropped at any point during the access.
module sram_wb_controller #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RDCLOCKS = 2,
  parameter int WRCLOCKS = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [1:0]    i_wb_sel,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [DW-1:0] o_wb_data,
  output logic          o_ram_ce_n,
  output logic          o_ram_oe_n,
  output logic          o_ram_we_n,
  output logic          o_ram_lb_n,
  output logic          o_ram_ub_n,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_data,
  output logic          o_ram_drive,
  input  logic [DW-1:0] i_ram_data,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WHOLD = 2'd3
  } state_t;

  localparam logic [3:0] RD_LAST = 4'(RDCLOCKS);
  localparam logic [3:0] WR_LAST = 4'(WRCLOCKS);

  state_t     state;
  logic [3:0] cnt;
  logic       abort;

  // Stall is a direct function of state, so the cycle that carries the ack
  // of a read can already accept the next request.
  assign o_wb_stall  = (state != IDLE);
  assign o_dbg_state = state;

  // Controller FSM: all SRAM pins and the ack are registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      abort       <= 1'b0;
      o_wb_ack    <= 1'b0;
      o_wb_data   <= '0;
      o_ram_ce_n  <= 1'b1;
      o_ram_oe_n  <= 1'b1;
      o_ram_we_n  <= 1'b1;
      o_ram_lb_n  <= 1'b1;
      o_ram_ub_n  <= 1'b1;
      o_ram_addr  <= '0;
      o_ram_data  <= '0;
      o_ram_drive <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      case (state)
        IDLE: begin
          abort       <= 1'b0;
          o_ram_drive <= 1'b0;
          o_ram_ce_n  <= 1'b1;
          o_ram_oe_n  <= 1'b1;
          o_ram_we_n  <= 1'b1;
          o_ram_lb_n  <= 1'b1;
          o_ram_ub_n  <= 1'b1;
          if (i_wb_cyc && i_wb_stb) begin
            // Address, lanes and write data are latched straight onto the pins.
            o_ram_addr <= i_wb_addr;
            o_ram_lb_n <= !i_wb_sel[0];
            o_ram_ub_n <= !i_wb_sel[1];
            o_ram_ce_n <= 1'b0;
            cnt        <= 4'd1;
            if (i_wb_we) begin
              o_ram_data  <= i_wb_data;
              o_ram_we_n  <= 1'b0;
              o_ram_drive <= 1'b1;
              state       <= WRITE;
            end else begin
              o_ram_oe_n <= 1'b0;
              state      <= READ;
            end
          end
        end
        READ: begin
          if (!i_wb_cyc) abort <= 1'b1;
          if (cnt == RD_LAST) begin
            o_wb_data  <= i_ram_data;
            o_ram_ce_n <= 1'b1;
            o_ram_oe_n <= 1'b1;
            o_ram_lb_n <= 1'b1;
            o_ram_ub_n <= 1'b1;
            o_wb_ack   <= i_wb_cyc && !abort;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          if (!i_wb_cyc) abort <= 1'b1;
          if (cnt == WR_LAST) begin
            // Strobes rise; address, data and drive stay for the hold cycle.
            o_ram_ce_n <= 1'b1;
            o_ram_we_n <= 1'b1;
            o_ram_lb_n <= 1'b1;
            o_ram_ub_n <= 1'b1;
            o_wb_ack   <= i_wb_cyc && !abort;
            state      <= WHOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WHOLD: begin
          o_ram_drive <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb_controller.sv
// Directed bench for sram_wb_controller with an asynchronous SRAM model,
// an expected-response queue popped by an ack monitor, and pin-rule checks.
module tb_sram_wb_controller;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          i_clk;
  logic          i_reset;
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic [1:0]    i_wb_sel;
  logic          o_wb_stall;
  logic          o_wb_ack;
  logic [DW-1:0] o_wb_data;
  logic          o_ram_ce_n;
  logic          o_ram_oe_n;
  logic          o_ram_we_n;
  logic          o_ram_lb_n;
  logic          o_ram_ub_n;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_data;
  logic          o_ram_drive;
  logic [DW-1:0] i_ram_data;
  logic [1:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  logic          prev_ack = 1'b0;
  logic [DW-1:0] mem [0:65535];

  sram_wb_controller #(.AW(AW), .DW(DW), .RDCLOCKS(2), .WRCLOCKS(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_ram_ce_n(o_ram_ce_n), .o_ram_oe_n(o_ram_oe_n), .o_ram_we_n(o_ram_we_n),
    .o_ram_lb_n(o_ram_lb_n), .o_ram_ub_n(o_ram_ub_n),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_ram_drive(o_ram_drive), .i_ram_data(i_ram_data),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Asynchronous SRAM model: combinational read, byte-lane write on each clock
  // where the write strobe is low.
  assign i_ram_data = (!o_ram_ce_n && !o_ram_oe_n) ? mem[o_ram_addr] : 16'h0000;
  always @(posedge i_clk) begin
    if (!o_ram_ce_n && !o_ram_we_n) begin
      if (!o_ram_lb_n) mem[o_ram_addr][7:0]  <= o_ram_data[7:0];
      if (!o_ram_ub_n) mem[o_ram_addr][15:8] <= o_ram_data[15:8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks pin rules per cycle.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      chk("pin_rules",
          {29'd0, (!o_ram_oe_n && !o_ram_we_n), (o_ram_drive && !o_ram_oe_n),
           (o_wb_ack && prev_ack)}, 32'd0);
      if (o_wb_ack) begin
        if (exp_q.size() == 0) chk("ack_expected", 32'(exp_q.size()), 32'd1);
        else chk("ack_data", {16'd0, o_wb_data}, {16'd0, exp_q.pop_front()});
      end
    end
    prev_ack = o_wb_ack;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Driver: present a request, wait for acceptance, report stalled cycles.
  // Returns one #1 into cycle 1 of the access.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [1:0] sel,
                       input logic [DW-1:0] rd_exp, input bit expect_ack,
                       output int waited);
    int n = 0;
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = data;
    i_wb_sel  = sel;
    while (o_wb_stall && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    if (expect_ack) begin
      if (!we) last_rd = rd_exp;
      exp_q.push_back(last_rd);
    end
    step();
    i_wb_stb = 1'b0;
    waited = n;
  endtask

  task automatic drain();
    int n = 0;
    while ((o_wb_stall || exp_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(n), 32'd0);
    step();
  endtask

  initial begin
    int w;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0010] = 16'h1122;
    mem[16'h0040] = 16'h7777;
    i_reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = 2'b00;
    repeat (3) step();
    i_reset = 1'b0;
    step();

    // Reset state
    chk("rst_ctrl", {27'd0, o_ram_ce_n, o_ram_oe_n, o_ram_we_n, o_ram_lb_n, o_ram_ub_n}, 32'h1F);
    chk("rst_drive_ack_stall", {29'd0, o_ram_drive, o_wb_ack, o_wb_stall}, 32'd0);
    chk("rst_data", {o_ram_addr, o_wb_data}, 32'd0);

    // Single read of 0x1234
    issue(1'b0, 16'h1234, 16'h0, 2'b11, 16'hBEEF, 1'b1, w);
    chk("rd_c1", {12'd0, o_ram_addr, o_ram_ce_n, o_ram_oe_n, o_ram_we_n, o_wb_stall}, {12'd0, 16'h1234, 4'b0011});
    step();
    chk("rd_c2", {12'd0, o_ram_addr, o_ram_ce_n, o_ram_oe_n, o_ram_drive, o_wb_stall}, {12'd0, 16'h1234, 4'b0001});
    step();
    chk("rd_c3", {13'd0, o_wb_data, o_wb_ack, o_ram_ce_n, o_wb_stall}, {13'd0, 16'hBEEF, 3'b110});
    drain();

    // Write 0xA55A to 0x0010, low byte only
    issue(1'b1, 16'h0010, 16'hA55A, 2'b01, 16'h0, 1'b1, w);
    chk("wr_c1", {27'd0, o_ram_we_n, o_ram_oe_n, o_ram_lb_n, o_ram_ub_n, o_ram_drive}, 32'b01011);
    step();
    chk("wr_c2", {11'd0, o_ram_data, o_ram_we_n, o_ram_lb_n, o_ram_ub_n, o_ram_ce_n, o_ram_drive}, {11'd0, 16'hA55A, 5'b00101});
    step();
    chk("wr_c3", {28'd0, o_wb_ack, o_ram_drive, o_ram_we_n, o_ram_ce_n}, 32'b1111);
    step();
    chk("wr_c4", {30'd0, o_ram_drive, o_wb_stall}, 32'd0);
    drain();
    issue(1'b0, 16'h0010, 16'h0, 2'b11, 16'h115A, 1'b1, w);
    drain();

    // Back-to-back write then read: read waits through WRITE, WRITE, WHOLD
    issue(1'b1, 16'h0020, 16'hCAFE, 2'b11, 16'h0, 1'b1, w);
    issue(1'b0, 16'h0020, 16'h0, 2'b11, 16'hCAFE, 1'b1, w);
    chk("b2b_wait", 32'(w), 32'd3);
    drain();

    // Zero byte selects: write leaves memory alone, read runs with lanes high
    issue(1'b1, 16'h0040, 16'h0000, 2'b00, 16'h0, 1'b1, w);
    chk("wr_sel0_lanes", {29'd0, o_ram_lb_n, o_ram_ub_n, o_ram_we_n}, 32'b110);
    drain();
    issue(1'b0, 16'h0040, 16'h0, 2'b00, 16'h7777, 1'b1, w);
    chk("rd_sel0_lanes", {29'd0, o_ram_lb_n, o_ram_ub_n, o_ram_oe_n}, 32'b110);
    drain();

    // Cycle dropped on cycle 1 of a read
    issue(1'b0, 16'h1234, 16'h0, 2'b11, 16'h0, 1'b0, w);
    i_wb_cyc = 1'b0;
    step();
    chk("abort_c2", {30'd0, o_ram_ce_n, o_ram_oe_n}, 32'd0);
    step();
    chk("abort_c3", {29'd0, o_wb_ack, o_ram_ce_n, o_wb_stall}, 32'b010);
    issue(1'b0, 16'h0010, 16'h0, 2'b10, 16'h115A, 1'b1, w);
    chk("abort_next_wait", 32'(w), 32'd0);
    drain();

    // Reset on cycle 1 of a write
    issue(1'b1, 16'h0030, 16'h1357, 2'b11, 16'h0, 1'b0, w);
    i_reset = 1'b1;
    step();
    chk("rst_mid", {27'd0, o_ram_ce_n, o_ram_we_n, o_ram_drive, o_wb_ack, o_wb_stall}, 32'b11000);
    chk("rst_mid_state", {30'd0, o_dbg_state}, 32'd0);
    i_reset = 1'b0;
    i_wb_cyc = 1'b0;
    last_rd = '0;
    step();
    issue(1'b0, 16'h1234, 16'h0, 2'b11, 16'hBEEF, 1'b1, w);
    drain();

    i_wb_cyc = 1'b0;
    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_wb_controller.md
Name: sram_wb_controller

Overview:
- Wishbone (pipelined, classic-compatible) slave that drives an external asynchronous 16-bit SRAM: chip enable, output enable, write enable, byte lanes, address and data bus.
- Sits directly upstream of the SRAM pins. Its pin outputs are the signals our SRAM timing property checker consumes.
- Every pin-level access holds address and control stable for a programmable number of clocks, so the tAA/tWC/tPWE/tHD constraints hold at the chosen clock rate.

Parameters:
- AW, 16, SRAM word-address width.
- DW, 16, data width; two byte lanes (fixed at 16).
- RDCLOCKS, 2, clocks ce_n/oe_n are held low before read data is sampled (1..15).
- WRCLOCKS, 2, clocks we_n is held low per write (1..15).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write
- i_wb_addr  in  AW  word address
- i_wb_data  in  DW  write data
- i_wb_sel  in  2  byte selects, bit0 = low byte
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_ack  out  1  one-cycle completion pulse
- o_wb_data  out  DW  read data
- o_ram_ce_n, o_ram_oe_n, o_ram_we_n  out  1 each  active-low SRAM controls
- o_ram_lb_n, o_ram_ub_n  out  1 each  active-low byte lanes
- o_ram_addr  out  AW  SRAM address
- o_ram_data  out  DW  data to pad
- o_ram_drive  out  1  pad output enable (1 = controller drives bus)
- i_ram_data  in  DW  data from pad

Behaviour:
- Reset values:
  - ce_n, oe_n, we_n, lb_n, ub_n = 1
  - o_ram_addr = 0, o_ram_data = 0, o_ram_drive = 0
  - o_wb_ack = 0, o_wb_data = 0
  - state = IDLE
- Reset mid-access aborts the access. Pins return to reset values on the next edge and no ack is issued.
- o_wb_stall = (state != IDLE). A request is accepted when i_wb_cyc && i_wb_stb && !o_wb_stall. On acceptance, addr/data/sel/we are latched.
- States: IDLE, READ, WRITE, WHOLD. A counter (4 bits) counts clocks within READ/WRITE.
- Read, with the request accepted at cycle 0:
  - Cycles 1..RDCLOCKS: ce_n=0, oe_n=0, we_n=1, lb_n=!sel[0], ub_n=!sel[1], addr stable, drive=0.
  - End of cycle RDCLOCKS: i_ram_data is registered into o_wb_data.
  - Cycle RDCLOCKS+1: o_wb_ack=1, all controls high, state IDLE, stall=0. A new request may be accepted this cycle.
- Write, with the request accepted at cycle 0:
  - Cycles 1..WRCLOCKS: ce_n=0, we_n=0, oe_n=1, byte lanes from sel, addr and o_ram_data stable, drive=1.
  - Cycle WRCLOCKS+1 (WHOLD): ce_n=we_n=1, addr/data/drive still held for data-hold time, o_wb_ack=1.
  - Cycle WRCLOCKS+2: drive=0, state IDLE.
- oe_n and we_n are never low in the same cycle. drive=1 never coincides with oe_n=0.
- Address, byte lanes and controls never change while ce_n is low within one access. Every access returns ce_n high for at least one cycle before the next.
- Write with sel=0: full write timing runs with lb_n=ub_n=1; ack is issued; memory is unchanged.
- Read with sel=0: full read timing runs with lb_n=ub_n=1; ack is issued; o_wb_data is sampled as normal.
- i_wb_cyc dropped mid-access: the pin sequence completes unchanged, so SRAM timing is preserved, and the pending ack is suppressed. An abort flag stays set until IDLE.
- o_wb_data holds the last read value until the next read completes. Writes do not alter it.
- o_wb_ack is never high for two consecutive cycles.

Test Plan:
- Reset is held for 3 cycles, then released with no requests -> all control pins are 1, drive=0, ack=0, stall=0.
- Single read to addr 0x1234 with sel=2'b11 and RDCLOCKS=2, while the SRAM model returns 0xBEEF:
  - ce_n/oe_n are low on cycles 1-2 and addr = 0x1234 throughout.
  - ack is on cycle 3 with o_wb_data = 0xBEEF.
  - stall is high on cycles 1-2.
- Write 0xA55A to 0x0010 with sel=2'b01 and WRCLOCKS=2:
  - we_n is low on cycles 1-2 with lb_n=0 and ub_n=1.
  - ack is on cycle 3 with drive still 1; drive=0 on cycle 4.
  - Readback returns only the low byte 0x5A merged.
- Back-to-back pipelined write then read: the write acks, the read is accepted the cycle stall drops, and oe_n is never low while drive=1.
- i_wb_cyc dropped on cycle 1 of a read -> the pin sequence still runs 2 cycles, no ack is issued, and the next request is accepted normally.
- i_reset asserted on cycle 1 of a write -> on the next cycle ce_n=we_n=1, drive=0, there is no ack, and the controller is IDLE.
